// File: rtl/ln_denorm.sv
// Layer-norm inverse: rebuilds code*sigma+mean per frame and replays
// each reconstructed group as one gap-free burst.
module ln_denorm #(
  parameter int GROUP = 8,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  localparam int CW = $clog2(GROUP + 2);
  localparam int IW = $clog2(GROUP);
  localparam logic [CW-1:0] LAST = CW'(GROUP + 1);
  localparam logic [IW:0]   OEND = (IW+1)'(GROUP);
  localparam logic [DW-1:0] MAXD = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MIND = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state;
  logic [CW-1:0]         beat;
  logic [IW:0]           ocnt;
  logic [DW-1:0]         mean_q;
  logic [DW-1:0]         sigma_q;
  logic [DW-1:0]         ibuf [GROUP];
  logic [DW-1:0]         obuf [GROUP];
  logic signed [2*DW-1:0] prod;
  logic signed [2*DW:0]   sum;
  logic [DW-1:0]         sat;
  logic [IW-1:0]         slot;
  logic                  last;

  assign last = in_valid && (beat == LAST);
  assign slot = IW'(beat - CW'(2));

  // Operands sign-extended to full width so the product is exact.
  assign prod = $signed({{DW{in_data[DW-1]}}, in_data})
              * $signed({{DW{sigma_q[DW-1]}}, sigma_q});
  assign sum  = $signed({prod[2*DW-1], prod})
              + $signed({{(DW+1){mean_q[DW-1]}}, mean_q});

  always_comb begin
    sat = sum[DW-1:0];
    if (sum > $signed({{(DW+1){1'b0}}, MAXD}))
      sat = MAXD;
    else if (sum < $signed({{(DW+1){1'b1}}, MIND}))
      sat = MIND;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat    <= '0;
      mean_q  <= '0;
      sigma_q <= '0;
      for (int i = 0; i < GROUP; i++)
        ibuf[i] <= '0;
    end else if (in_valid) begin
      beat <= last ? '0 : beat + CW'(1);
      if (beat == CW'(0))
        mean_q <= in_data;
      else if (beat == CW'(1))
        sigma_q <= in_data[DW-1] ? '0 : in_data;
      else
        ibuf[slot] <= sat;
    end
  end

  // Handoff wins over the running burst so BURST->BURST works.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ocnt      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < GROUP; i++)
        obuf[i] <= '0;
    end else if (last) begin
      for (int i = 0; i < GROUP; i++)
        obuf[i] <= (i == GROUP - 1) ? sat : ibuf[i];
      state     <= BURST;
      ocnt      <= (IW+1)'(1);
      out_valid <= 1'b1;
      out_data  <= ibuf[0];
    end else begin
      unique case (state)
        IDLE: begin
          out_valid <= 1'b0;
          out_data  <= '0;
        end
        BURST: begin
          if (ocnt == OEND) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
          end else begin
            out_valid <= 1'b1;
            out_data  <= obuf[ocnt[IW-1:0]];
            ocnt      <= ocnt + (IW+1)'(1);
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_data  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ln_denorm.sv
// Scoreboard bench for ln_denorm: hand-computed bursts checked for
// value and exact cycle of arrival.
module tb_ln_denorm;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_valid;
  logic [7:0] out_data;

  ln_denorm #(.GROUP(8), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int d; int c; } exp_t;
  exp_t sb[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(string nm, int act, int want);
    n_chk++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, want, cyc);
    end
  endtask

  // Monitor: pops one expectation per valid output beat.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious: got %0d expected no output (cycle %0d)",
                 $signed(out_data), cyc);
      end else begin
        e = sb.pop_front();
        check("data", int'($signed(out_data)), e.d);
        check("cycle", cyc, e.c);
      end
    end else begin
      check("idle_valid", int'(out_valid === 1'b0), 1);
      check("idle_data", int'(out_data), 0);
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'h00;
    end
  endtask

  task automatic send_frame(int mean, int sigma, int codes[8],
                            int want[8], bit gap, bit push, int nb);
    int beats[10];
    beats[0] = mean;
    beats[1] = sigma;
    for (int i = 0; i < 8; i++) beats[i+2] = codes[i];
    for (int b = 0; b < nb; b++) begin
      if (gap && b > 0) begin
        int k;
        k = $urandom_range(1, 3);
        repeat (k) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_data  = 8'h5a;
        end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(beats[b]);
      if (b == 9 && push)
        for (int i = 0; i < 8; i++)
          sb.push_back('{want[i], cyc + 1 + i});
      @(posedge clk);
    end
  endtask

  int c[8];
  int e[8];

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", int'(out_data), 0);
    rst = 1'b0;

    c = '{0, 1, -1, 2, -2, 3, -3, 4};
    e = '{10, 15, 5, 20, 0, 25, -5, 30};
    send_frame(10, 5, c, e, 1'b0, 1'b1, 10);
    idle(12);

    c = '{1, -1, 4, -4, 0, 2, -2, -3};
    e = '{127, 50, 127, -100, 100, 127, 0, -50};
    send_frame(100, 50, c, e, 1'b0, 1'b1, 10);
    idle(12);

    c = '{-128, 127, 0, 1, -1, 2, -2, 64};
    e = '{-128, 127, -128, -1, -128, 126, -128, 127};
    send_frame(-128, 127, c, e, 1'b0, 1'b1, 10);
    idle(12);

    c = '{1, -1, 5, -5, 127, -128, 0, 3};
    e = '{7, 7, 7, 7, 7, 7, 7, 7};
    send_frame(7, -3, c, e, 1'b0, 1'b1, 10);
    idle(12);

    c = '{1, 2, 3, 4, 5, 6, 7, 8};
    e = '{2, 4, 6, 8, 10, 12, 14, 16};
    send_frame(0, 2, c, e, 1'b0, 1'b1, 10);
    c = '{0, 1, 2, 3, -1, -2, -3, 10};
    e = '{-5, -2, 1, 4, -8, -11, -14, 25};
    send_frame(-5, 3, c, e, 1'b0, 1'b1, 10);
    idle(12);

    c = '{0, 1, -1, 2, -2, 3, -3, 4};
    e = '{10, 15, 5, 20, 0, 25, -5, 30};
    send_frame(10, 5, c, e, 1'b1, 1'b1, 10);
    idle(12);

    c = '{1, 2, 3, 4, 5, 6, 7, 8};
    send_frame(50, 10, c, e, 1'b0, 1'b0, 6);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_data", int'(out_data), 0);
    rst = 1'b0;
    c = '{0, 1, 2, 3, 4, 5, 6, 7};
    e = '{0, 1, 2, 3, 4, 5, 6, 7};
    send_frame(0, 1, c, e, 1'b0, 1'b1, 10);
    idle(12);

    begin
      int t;
      t = 0;
      while (sb.size() > 0 && t < 50) begin
        @(negedge clk);
        t++;
      end
      check("drain", sb.size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
